delay_sched: RTL and testbench

- Round-robin scheduler that shares one CBITS-wide delay counter among NREQ requesters.
- Each requester asks for a one-shot delayed pulse of programmable length.
- The block grants one requester at a time, loads that requester's delay into the shared counter and counts it down.
- When the count finishes, it returns a one-cycle done pulse to the granted requester.
- Sits between periodic-event clients (tick/timeout users) and the single counter resource.

---
 rtl/delay_sched_pkg.sv | 18 +
 rtl/delay_sched_rr_arb.sv | 28 ++
 rtl/delay_sched.sv | 99 +++++++++
 tb/tb_delay_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// rtl/delay_sched_pkg.sv - shared types, defaults and helpers for the delay scheduler
package delay_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int CBITS_DEF = 10;
    localparam int ONEHOT_W  = 32;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    // Callers narrow the result to their own requester count.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/delay_sched_rr_arb.sv
// rtl/delay_sched_rr_arb.sv - combinational round-robin picker starting at ptr
module delay_sched_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - shares one down-counter among requesters, one delayed done pulse per grant
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CBITS = CBITS_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] delay,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [IDW-1:0]        cur_id
);

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;

    logic             arb_valid;
    logic [IDW-1:0]   arb_winner;
    logic [CBITS-1:0] delay_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign delay_arr[i] = delay[i*CBITS +: CBITS];
    end

    delay_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        cur_id_d = cur_id_q;
        gnt_d    = '0;
        done_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    gnt_d    = NREQ'(onehot(32'(arb_winner)));
                    cur_id_d = arb_winner;
                    cnt_d    = delay_arr[arb_winner];
                    ptr_d    = (arb_winner == IDW'(NREQ-1)) ? '0 : arb_winner + 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_COUNT;
                end
            end
            default: begin
                // Counter saturates at zero; the zero cycle itself issues done.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CBITS'(1);
                end else begin
                    done_d  = NREQ'(onehot(32'(cur_id_q)));
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign cur_id = cur_id_q;

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - directed self-checking bench for delay_sched
module tb_delay_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 10;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] delay = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [IDW-1:0]        cur_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .delay  (delay),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cur_id (cur_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int idx, input int val);
        delay[idx*CBITS +: CBITS] = CBITS'(val);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_onehot0(input string tag);
        check(tag, 32'($countones({gnt, done}) <= 1), 32'd1);
    endtask

    logic early;

    initial begin
        // Reset held with all requests pending
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_delay(i, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_done", 32'(done), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        check("rst_cur_id", 32'(cur_id), 32'h0);
        rst = 1'b0;
        step();
        check("first_gnt", 32'(gnt), 32'h1);
        do_reset();

        // Single requester, delay 5
        req = 4'b0100;
        set_delay(2, 5);
        step();
        check("d5_gnt", 32'(gnt), 32'h4);
        check("d5_cur_id", 32'(cur_id), 32'h2);
        check("d5_busy0", 32'(busy), 32'h1);
        req = '0;
        set_delay(2, 40);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("d5_busy", 32'(busy), 32'h1);
            check("d5_done_early", 32'(done), 32'h0);
            check("d5_gnt_once", 32'(gnt), 32'h0);
        end
        step();
        check("d5_done", 32'(done), 32'h4);
        check("d5_busy_end", 32'(busy), 32'h0);
        step();
        check("d5_done_pulse", 32'(done), 32'h0);

        // Zero delay with held request
        req = 4'b0010;
        set_delay(1, 0);
        step();
        check("d0_gnt", 32'(gnt), 32'h2);
        step();
        check("d0_done", 32'(done), 32'h2);
        check("d0_gnt_clear", 32'(gnt), 32'h0);
        check("d0_busy", 32'(busy), 32'h0);
        step();
        check("d0_regrant", 32'(gnt), 32'h2);
        check("d0_regrant_done", 32'(done), 32'h0);
        req = '0;
        step();
        check("d0_done2", 32'(done), 32'h2);
        do_reset();

        // All requesters, delay 3: order 0,1,2,3,0 spaced 5 cycles
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_delay(i, 3);
        step();
        check("rr_gnt0", 32'(gnt), 32'h1);
        for (int g = 1; g <= 4; g++) begin
            for (int k = 1; k <= 4; k++) begin
                step();
                check("rr_gap", 32'(gnt), 32'h0);
                check_onehot0("rr_onehot");
            end
            step();
            check("rr_gnt", 32'(gnt), 32'(1 << (g % NREQ)));
            check_onehot0("rr_onehot");
        end
        req = '0;
        for (int k = 0; k < 6; k++) step();
        check("rr_idle", 32'(busy), 32'h0);

        // Reset in the middle of a long count
        do_reset();
        req = 4'b0001;
        set_delay(0, 100);
        step();
        check("abort_gnt", 32'(gnt), 32'h1);
        req = '0;
        early = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (done != '0) early = 1'b1;
        end
        check("abort_no_done_pre", 32'(early), 32'h0);
        rst = 1'b1;
        req = 4'b1010;
        step();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        set_delay(1, 0);
        step();
        check("abort_next_gnt", 32'(gnt), 32'h2);
        req = '0;
        early = 1'b0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (done[0]) early = 1'b1;
        end
        check("abort_no_done0", 32'(early), 32'h0);

        // Maximum delay, delay input changed after grant
        do_reset();
        req = 4'b1000;
        set_delay(3, 1023);
        step();
        check("max_gnt", 32'(gnt), 32'h8);
        set_delay(3, 2);
        req = '0;
        early = 1'b0;
        for (int k = 1; k <= 1023; k++) begin
            step();
            if (done != '0 || !busy) early = 1'b1;
        end
        check("max_no_early", 32'(early), 32'h0);
        step();
        check("max_done", 32'(done), 32'h8);
        check("max_busy_end", 32'(busy), 32'h0);
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done != '0 || busy || gnt != '0) early = 1'b1;
        end
        check("max_no_wrap", 32'(early), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
